// File: rtl/core_clk_sequencer.sv
// Qualifies PLL lock, sequences a clean core reset and produces a fractional
// single-cycle clock enable (f_clk * NUM / DEN) for the emulated MCU core.
module core_clk_sequencer #(
  parameter int NUM         = 1,
  parameter int DEN         = 50,
  parameter int LOCK_FILTER = 1024,
  parameter int RESET_HOLD  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_reset,
  input  logic pause,
  input  logic clr_lost,
  output logic core_reset,
  output logic ce,
  output logic running,
  output logic lock_lost
);

  localparam int ACC_W  = $clog2(DEN) + 1;
  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  localparam logic [ACC_W-1:0]  NUM_C     = ACC_W'(NUM);
  localparam logic [ACC_W-1:0]  DEN_C     = ACC_W'(DEN);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    HOLD,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic               sync_p0, sync_p1;
  logic               locked_s;
  logic [FILT_W-1:0]  filt_q, filt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W:0]     step;
  logic               ce_d;
  logic               lost_set;

  // One accumulator step: acc < DEN and NUM < DEN keep the sum below 2^ACC_W.
  // Returns {wrap, next_acc}.
  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc_cur);
    logic [ACC_W-1:0] sum;
    sum = acc_cur + NUM_C;
    if (sum >= DEN_C) begin
      acc_step = {1'b1, sum - DEN_C};
    end else begin
      acc_step = {1'b0, sum};
    end
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      sync_p1 <= sync_p0;
    end
  end

  assign locked_s = sync_p1;

  // Next-state logic; lock loss outranks soft reset, which outranks pause
  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    hold_d   = hold_q;
    acc_d    = acc_q;
    ce_d     = 1'b0;
    lost_set = 1'b0;
    step     = acc_step(acc_q);

    case (state_q)
      WAIT_LOCK: begin
        filt_d = '0;
        hold_d = '0;
        acc_d  = '0;
        if (locked_s) begin
          state_d = FILTER;
        end
      end

      FILTER: begin
        acc_d = '0;
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = HOLD;
          filt_d  = '0;
          hold_d  = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end

      HOLD: begin
        acc_d = '0;
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else if (soft_reset) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      RUN: begin
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          acc_d    = '0;
          lost_set = 1'b1;
        end else if (soft_reset) begin
          state_d = HOLD;
          hold_d  = '0;
          acc_d   = '0;
        end else if (!pause) begin
          acc_d = step[ACC_W-1:0];
          ce_d  = step[ACC_W];
        end
      end

      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  // Registered state and outputs; outputs derive from next state so no
  // input reaches an output without passing a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_LOCK;
      filt_q     <= '0;
      hold_q     <= '0;
      acc_q      <= '0;
      core_reset <= 1'b1;
      ce         <= 1'b0;
      running    <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state_q    <= state_d;
      filt_q     <= filt_d;
      hold_q     <= hold_d;
      acc_q      <= acc_d;
      core_reset <= (state_d != RUN);
      running    <= (state_d == RUN);
      ce         <= ce_d;
      if (lost_set) begin
        lock_lost <= 1'b1;
      end else if (clr_lost) begin
        lock_lost <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_clk_sequencer.sv
// Scoreboard bench for core_clk_sequencer: expected ce cycles are queued by the
// stimulus and popped by a monitor; a second instance checks a 3/7 rate.
module tb_core_clk_sequencer;

  logic clk = 1'b0;
  logic rst, pll_locked, soft_reset, pause, clr_lost;
  logic core_reset, ce, running, lock_lost;

  logic rst_f, pll_locked_f;
  logic core_reset_f, ce_f, running_f, lock_lost_f;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  int mon_exp;
  bit frac_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_clk_sequencer #(.NUM(1), .DEN(5), .LOCK_FILTER(8), .RESET_HOLD(4)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_reset(soft_reset),
    .pause(pause), .clr_lost(clr_lost), .core_reset(core_reset), .ce(ce),
    .running(running), .lock_lost(lock_lost)
  );

  core_clk_sequencer #(.NUM(3), .DEN(7), .LOCK_FILTER(8), .RESET_HOLD(4)) dut_f (
    .clk(clk), .rst(rst_f), .pll_locked(pll_locked_f), .soft_reset(1'b0),
    .pause(1'b0), .clr_lost(1'b0), .core_reset(core_reset_f), .ce(ce_f),
    .running(running_f), .lock_lost(lock_lost_f)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Wait for core_reset release, check its latency from ref_c, then queue
  // npulse ce pulses every 5 cycles and wait until the last one is due.
  task automatic wait_run(input string name, input int ref_c, input int lo, input int hi,
                          input int npulse, output int last);
    int guard;
    int f;
    guard = 0;
    while (core_reset !== 1'b0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (core_reset !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: core_reset still %b after 60 cycles, expected 0", name, core_reset);
      last = cyc;
      return;
    end
    check_range(name, cyc - ref_c, lo, hi);
    check({name, "_running"}, int'(running), 1);
    f = cyc;
    for (int k = 1; k <= npulse; k++) exp_q.push_back(f + 5 * k);
    last = f + 5 * npulse;
    while (cyc < last) @(negedge clk);
  endtask

  // Monitor: every ce pulse must match the next queued cycle, outside reset
  always @(negedge clk) begin
    if (ce === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ce_unexpected: ce pulse at cycle %0d, none expected", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp != cyc) begin
          n_fail++;
          $display("FAIL ce_timing: pulse at cycle %0d, expected cycle %0d", cyc, mon_exp);
        end
      end
      check("ce_vs_core_reset", int'(core_reset), 0);
    end
  end

  // Fractional-rate instance: 3/7 over 700 RUN cycles
  initial begin
    int guard;
    int count;
    int last;
    int gap;
    int maxg;
    int ming;
    rst_f = 1'b1;
    pll_locked_f = 1'b1;
    count = 0;
    last = -1;
    maxg = 0;
    ming = 1000;
    tick(2);
    rst_f = 1'b0;
    guard = 0;
    while (running_f !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("frac_running", int'(running_f), 1);
    repeat (700) begin
      @(negedge clk);
      if (ce_f === 1'b1) begin
        count++;
        if (last >= 0) begin
          gap = cyc - last;
          if (gap > maxg) maxg = gap;
          if (gap < ming) ming = gap;
        end
        last = cyc;
      end
    end
    check("frac_count", count, 300);
    check_range("frac_max_gap", maxg, 1, 3);
    check_range("frac_min_gap", ming, 2, 7);
    check("frac_core_reset", int'(core_reset_f), 0);
    check("frac_lock_lost", int'(lock_lost_f), 0);
    frac_done = 1'b1;
  end

  initial begin
    int r;
    int p;
    int guard;
    rst = 1'b1;
    pll_locked = 1'b1;
    soft_reset = 1'b0;
    pause = 1'b0;
    clr_lost = 1'b0;
    tick(3);
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_ce", int'(ce), 0);
    check("rst_running", int'(running), 0);
    check("rst_lock_lost", int'(lock_lost), 0);

    // Power-up: 2 sync + 8 filter + 4 hold, one cycle of tolerance either side
    rst = 1'b0;
    r = cyc;
    wait_run("powerup_release", r, 13, 16, 4, p);

    // Pause at acc = 2 for 7 cycles; next pulse 3 enabled cycles after release
    tick(2);
    pause = 1'b1;
    tick(7);
    pause = 1'b0;
    exp_q.push_back(cyc + 3);
    exp_q.push_back(cyc + 8);
    tick(8);

    // Soft reset in RUN: back to HOLD for 4 cycles
    soft_reset = 1'b1;
    r = cyc;
    tick(1);
    check("soft_core_reset", int'(core_reset), 1);
    check("soft_running", int'(running), 0);
    soft_reset = 1'b0;
    wait_run("soft_release", r, 4, 6, 2, p);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(3);
    check("loss_core_reset", int'(core_reset), 1);
    check("loss_ce", int'(ce), 0);
    check("loss_running", int'(running), 0);
    check("loss_lock_lost", int'(lock_lost), 1);
    pll_locked = 1'b1;
    r = cyc;
    wait_run("relock_release", r, 13, 16, 1, p);
    check("lock_lost_persist", int'(lock_lost), 1);
    clr_lost = 1'b1;
    tick(1);
    clr_lost = 1'b0;
    check("lock_lost_cleared", int'(lock_lost), 0);

    // Lock glitch during FILTER restarts the filter count
    pll_locked = 1'b0;
    tick(4);
    clr_lost = 1'b1;
    tick(1);
    clr_lost = 1'b0;
    check("pre_glitch_lock_lost", int'(lock_lost), 0);
    pll_locked = 1'b1;
    r = cyc;
    tick(5);
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(8);
    check("glitch_core_reset", int'(core_reset), 1);
    check("glitch_lock_lost", int'(lock_lost), 0);
    wait_run("glitch_release", r, 21, 24, 2, p);

    // Soft reset and lock loss in the same cycle: lock loss wins
    pll_locked = 1'b0;
    tick(2);
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    check("both_core_reset", int'(core_reset), 1);
    check("both_running", int'(running), 0);
    check("both_lock_lost", int'(lock_lost), 1);
    pll_locked = 1'b1;
    r = cyc;
    wait_run("both_release", r, 13, 16, 1, p);

    // Asynchronous reset mid-pulse, between clock edges
    #2;
    rst = 1'b1;
    #1;
    check("async_ce", int'(ce), 0);
    check("async_core_reset", int'(core_reset), 1);
    check("async_running", int'(running), 0);
    check("async_lock_lost", int'(lock_lost), 0);

    guard = 0;
    while (!frac_done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("frac_finished", int'(frac_done), 1);
    check("ce_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_clk_sequencer.md
Name: core_clk_sequencer

Overview:
- Sits directly downstream of the system PLL, in its 20 MHz output domain.
- Qualifies the PLL `locked` signal and sequences a clean core reset.
- Generates a fractional single-cycle clock enable (default 20 MHz → 400 kHz) that paces the emulated MCU core.
- Supports pause (OSD/menu) and soft reset without stopping the clock.

Parameters:
- NUM, 1: enable-rate numerator; 1 ≤ NUM < DEN.
- DEN, 50: enable-rate denominator; ce rate = f_clk × NUM / DEN.
- LOCK_FILTER, 1024: consecutive synchronised-locked cycles required before leaving lock qualification; ≥ 1.
- RESET_HOLD, 16: cycles core_reset stays high after lock is qualified or after soft reset; ≥ 1.

Ports:
- clk, in, 1: 20 MHz PLL output clock; the only clock.
- rst, in, 1: asynchronous, active-high reset.
- pll_locked, in, 1: PLL locked; asynchronous to clk, synchronised internally.
- soft_reset, in, 1: level; while high, forces reset re-sequencing.
- pause, in, 1: level; freezes enable generation.
- clr_lost, in, 1: clears the lock_lost sticky flag.
- core_reset, out, 1: registered reset to core logic.
- ce, out, 1: registered single-cycle clock-enable pulse.
- running, out, 1: high in RUN state.
- lock_lost, out, 1: sticky; set when lock drops while in RUN.

Behaviour:
- Reset values under rst: state = WAIT_LOCK, core_reset = 1, ce = 0, running = 0, lock_lost = 0, acc = 0, counters = 0, sync flops = 0.
- Synchroniser: 2-flop synchroniser produces locked_s, with 2-cycle latency.
- Accumulator acc: width = clog2(DEN) + 1 bits; the sum acc + NUM is computed without overflow.
- WAIT_LOCK:
  - core_reset = 1; count cleared.
  - locked_s = 1 → FILTER.
- FILTER:
  - Counts cycles with locked_s = 1.
  - locked_s = 0 → WAIT_LOCK, count cleared.
  - Count reaches LOCK_FILTER → HOLD.
- HOLD:
  - core_reset = 1, acc = 0; counts RESET_HOLD cycles, then → RUN.
  - soft_reset high restarts the hold count.
- RUN:
  - core_reset = 0, running = 1.
  - Each cycle with pause = 0: if acc + NUM ≥ DEN, then acc ← acc + NUM − DEN and ce ← 1; otherwise acc ← acc + NUM and ce ← 0.
  - pause = 1: acc holds, ce ← 0. Deasserting pause resumes from the held acc, so no phase is lost.
- Lock loss: locked_s = 0 in HOLD or RUN → WAIT_LOCK next edge.
  - core_reset = 1, ce = 0, running = 0, acc = 0 on that edge.
  - lock_lost ← 1 only if the state was RUN.
- soft_reset in RUN → HOLD next edge; ce = 0 on that edge.
- Priority when events coincide in one cycle: rst > lock loss > soft_reset > pause > normal.
- ce is never 1 while core_reset = 1. ce pulse width is exactly 1 cycle.
- Long-run rate: exactly NUM pulses per DEN RUN, non-paused cycles. With NUM/DEN = 1/50, pulses are exactly every 50 cycles.
- lock_lost clears on clr_lost = 1. If a set and clr_lost occur in the same cycle, set wins.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Bench parameters: LOCK_FILTER = 8, RESET_HOLD = 4, NUM = 1, DEN = 5.
- Power-up: release rst, pll_locked = 1 from cycle 0 → core_reset falls on cycle 2 + 8 + 4 (±1 for state entry) after rst release; first ce 5 cycles later; then ce every 5 cycles, each 1 cycle wide.
- Lock glitch: pll_locked low for 3 cycles during FILTER → returns to WAIT_LOCK; the FILTER count restarts; core_reset stays 1; lock_lost stays 0.
- Lock loss in RUN: drop pll_locked → within 3 cycles core_reset = 1, ce = 0, running = 0, lock_lost = 1; lock_lost persists after relock until clr_lost is pulsed.
- Pause: assert pause for 7 cycles in RUN at acc = 2 → no ce during pause; after release, next ce exactly 3 enabled cycles later.
- Fractional rate: NUM = 3, DEN = 7 over 700 RUN cycles → exactly 300 ce pulses; no two pulses adjacent except as the accumulator dictates; max gap 3 cycles.
- Simultaneous: soft_reset and lock loss in the same cycle → WAIT_LOCK (not HOLD); lock_lost = 1. Async rst asserted mid-RUN → all outputs at reset values immediately, without waiting for a clk edge.
